// File: rtl/aes_pkg.sv
// Shared definitions for the AES job arbiter: block width, core latency
// and the scheduler state encoding. The ABORT state only exists when the
// watchdog is built in (macro AES_ARB_TIMEOUT_EN).
package aes_pkg;

  localparam int AES_BLK_W       = 128;
  localparam int AES_CORE_CYCLES = 40;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_RUN   = 2'd1,
    ARB_RESP  = 2'd2
`ifdef AES_ARB_TIMEOUT_EN
    ,
    ARB_ABORT = 2'd3
`endif
  } arb_state_e;

endpackage

// File: rtl/aes_job_arbiter_rr.sv
// rr_arbiter: NREQ-way round-robin priority select. The search starts at
// ptr_i and wraps; the first asserted request wins. Outputs a one-hot grant,
// its encoded index and a flag saying any request was found.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  // Walk the requesters in rotated order and keep the first hit.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!any_o && (i == ((int'(ptr_i) + k) % NREQ)) && req_i[i]) begin
          any_o    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: shares one iterative AES-128 controller/core pair between
// NREQ requesters. One job at a time is accepted round-robin, its operands are
// registered onto the core inputs, start is held for one encryption and the
// ciphertext is returned tagged with the requester index.
// Optional watchdog: define AES_ARB_TIMEOUT_EN to abort jobs whose core never
// reports done within TIMEOUT RUN cycles (response carries resp_err=1).
//
// Handshakes: every valid/ready pair transfers on a rising edge where both
// are high; valid never waits on ready, and once resp_valid is high the
// response fields hold until the transfer. req_ready is only ever raised for
// a requester whose req_valid is high.
module aes_job_arbiter
  import aes_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 3,
  parameter int TIMEOUT = 63
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*AES_BLK_W-1:0] req_pt,
  input  logic [NREQ*AES_BLK_W-1:0] req_key,
  output logic [NREQ-1:0]           req_ready,
  output logic                      core_start,
  output logic [AES_BLK_W-1:0]      core_pt,
  output logic [AES_BLK_W-1:0]      core_key,
  input  logic                      core_accept,
  input  logic                      core_done,
  input  logic [AES_BLK_W-1:0]      core_ct,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [IDW-1:0]            resp_id,
  output logic [AES_BLK_W-1:0]      resp_ct,
  output logic                      resp_err,
  output logic [1:0]                dbg_state,
  output logic [IDW-1:0]            dbg_rr_ptr
);

  arb_state_e           state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]       cur_id_q, cur_id_d;
  logic [AES_BLK_W-1:0] core_pt_q, core_pt_d;
  logic [AES_BLK_W-1:0] core_key_q, core_key_d;
  logic [AES_BLK_W-1:0] resp_ct_q, resp_ct_d;
  logic [NREQ-1:0]      arb_req, gnt;
  logic [IDW-1:0]       gnt_idx, id_next;
  logic                 gnt_any;

`ifdef AES_ARB_TIMEOUT_EN
  logic       resp_err_q, resp_err_d;
  logic [6:0] wd_q, wd_d;
  logic       wd_hit;
  assign wd_hit   = (wd_q == 7'(TIMEOUT - 1));
  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  // Only offer requests to the arbiter when a grant is actually possible,
  // so req_ready stays low in every other state and while reset is held.
  assign arb_req = (rstn && (state_q == ARB_IDLE) && core_accept) ? req_valid : '0;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_i (arb_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Search restarts just after the requester that was last served.
  assign id_next = (cur_id_q == IDW'(NREQ - 1)) ? '0 : cur_id_q + 1'b1;

  assign core_pt    = core_pt_q;
  assign core_key   = core_key_q;
  assign resp_id    = cur_id_q;
  assign resp_ct    = resp_ct_q;
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

  // Next-state and output decode for the scheduler FSM.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cur_id_d   = cur_id_q;
    core_pt_d  = core_pt_q;
    core_key_d = core_key_q;
    resp_ct_d  = resp_ct_q;
`ifdef AES_ARB_TIMEOUT_EN
    resp_err_d = resp_err_q;
    wd_d       = wd_q;
`endif
    req_ready  = '0;
    core_start = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        req_ready = gnt;
        if (gnt_any) begin
          for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
              core_pt_d  = req_pt[AES_BLK_W*i +: AES_BLK_W];
              core_key_d = req_key[AES_BLK_W*i +: AES_BLK_W];
            end
          end
          cur_id_d = gnt_idx;
          state_d  = ARB_RUN;
`ifdef AES_ARB_TIMEOUT_EN
          resp_err_d = 1'b0;
          wd_d       = '0;
`endif
        end
      end
      ARB_RUN: begin
        // Start drops in the very cycle done is seen, so the controller
        // cannot roll into a second encryption.
`ifdef AES_ARB_TIMEOUT_EN
        core_start = ~core_done & ~wd_hit;
`else
        core_start = ~core_done;
`endif
        if (core_done) begin
          resp_ct_d = core_ct;
          rr_ptr_d  = id_next;
          state_d   = ARB_RESP;
        end
`ifdef AES_ARB_TIMEOUT_EN
        else if (wd_hit) begin
          resp_err_d = 1'b1;
          resp_ct_d  = '0;
          rr_ptr_d   = id_next;
          state_d    = ARB_ABORT;
        end else begin
          wd_d = wd_q + 7'd1;
        end
`endif
      end
`ifdef AES_ARB_TIMEOUT_EN
      ARB_ABORT: state_d = ARB_RESP;
`endif
      ARB_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      cur_id_q   <= '0;
      core_pt_q  <= '0;
      core_key_q <= '0;
      resp_ct_q  <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      resp_err_q <= 1'b0;
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_id_q   <= cur_id_d;
      core_pt_q  <= core_pt_d;
      core_key_q <= core_key_d;
      resp_ct_q  <= resp_ct_d;
`ifdef AES_ARB_TIMEOUT_EN
      resp_err_q <= resp_err_d;
      wd_q       <= wd_d;
`endif
    end
  end

endmodule
